load_store_unit: RTL and testbench

Initiator side of the CPU data-memory interface. Accepts load/store requests from the execute/memory stage and drives the word-wide data memory's MemoryRead/MemoryWrite/Address/WriteData strobes. Supports byte, halfword and word accesses with sign/zero extension. Since the memory is word-only, sub-word stores are done as read-modify-write. Misaligned and illegal-size requests are flagged without touching memory.

---
 rtl/load_store_unit_if.sv | 46 ++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the request/response handshake of the load/store unit together with
// its word-wide data-memory strobes.
//   Request  : ReqValid, ReqReady, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData
//   Response : RespValid, RespData, RespError
//   Memory   : MemAddress, MemWriteData, MemoryRead, MemoryWrite, MemReadData
// Modport master is taken by the load/store unit, which initiates every memory
// access and answers requests. Modport slave is the surrounding pipeline stage
// plus the data memory that it talks to.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 6
) ();

    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [1:0]            ReqSize;
    logic                  ReqSigned;
    logic [ADDR_WIDTH+1:0] ReqAddr;
    logic [31:0]           ReqWData;

    logic                  RespValid;
    logic [31:0]           RespData;
    logic                  RespError;

    logic [ADDR_WIDTH-1:0] MemAddress;
    logic [31:0]           MemWriteData;
    logic                  MemoryRead;
    logic                  MemoryWrite;
    logic [31:0]           MemReadData;

    modport master (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
        input  MemReadData,
        output ReqReady, RespValid, RespData, RespError,
        output MemAddress, MemWriteData, MemoryRead, MemoryWrite
    );

    modport slave (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
        output MemReadData,
        input  ReqReady, RespValid, RespData, RespError,
        input  MemAddress, MemWriteData, MemoryRead, MemoryWrite
    );

endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the CPU data-memory interface. Takes byte/half/word load
// and store requests and turns them into MemoryRead/MemoryWrite accesses on a
// word-only memory. Sub-word stores become read-modify-write sequences; loads
// are lane-extracted and sign/zero extended. Misaligned or illegal-size
// requests complete with RespError and never strobe the memory.
// Ports:
//   Clock   - rising-edge clock for all state
//   Reset_n - asynchronous active-low reset
//   bus     - load_store_unit_if.master (request, response, memory signals)
module load_store_unit #(
    parameter int ADDR_WIDTH = 6,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    load_store_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t                r_state;
    logic                  r_write;
    logic                  r_signed;
    logic [1:0]            r_size;
    logic [1:0]            r_lowAddr;
    logic [15:0]           r_wData;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [31:0]           r_memWData;
    logic [31:0]           r_respData;
    logic                  r_respError;

    logic                  w_reqError;
    logic [1:0]            w_byteLane;
    logic                  w_halfLane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_loadData;
    logic [31:0]           w_mergeData;

    // Alignment/size check on the live request; only looked at on acceptance.
    always_comb begin
        w_reqError = 1'b0;
        case (bus.ReqSize)
            2'b00:   w_reqError = 1'b0;
            2'b01:   w_reqError = bus.ReqAddr[0];
            2'b10:   w_reqError = |bus.ReqAddr[1:0];
            default: w_reqError = 1'b1;
        endcase
    end

    // Big-endian mirrors the lane: for a 2-bit lane, 3-x is simply ~x.
    assign w_byteLane = BIG_ENDIAN ? ~r_lowAddr : r_lowAddr;
    assign w_halfLane = BIG_ENDIAN ? ~r_lowAddr[1] : r_lowAddr[1];
    assign w_byte     = bus.MemReadData[{w_byteLane, 3'b000} +: 8];
    assign w_half     = bus.MemReadData[{w_halfLane, 4'b0000} +: 16];

    // Load result: selected lane extended per size/signed; words pass through.
    always_comb begin
        w_loadData = bus.MemReadData;
        case (r_size)
            2'b00:   w_loadData = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'b01:   w_loadData = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_loadData = bus.MemReadData;
        endcase
    end

    // Read-modify-write merge: overwrite only the addressed lane of the old word.
    always_comb begin
        w_mergeData = bus.MemReadData;
        if (r_size == 2'b00) begin
            w_mergeData[{w_byteLane, 3'b000} +: 8] = r_wData[7:0];
        end else begin
            w_mergeData[{w_halfLane, 4'b0000} +: 16] = r_wData;
        end
    end

    // Main FSM. Every output is either a register here or a pure decode of
    // r_state, so reset clears the memory strobes immediately and any write
    // whose falling edge has not yet come is dropped.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'b00;
            r_lowAddr   <= 2'b00;
            r_wData     <= 16'h0;
            r_memAddr   <= '0;
            r_memWData  <= 32'h0;
            r_respData  <= 32'h0;
            r_respError <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ReqValid) begin
                        r_write     <= bus.ReqWrite;
                        r_signed    <= bus.ReqSigned;
                        r_size      <= bus.ReqSize;
                        r_lowAddr   <= bus.ReqAddr[1:0];
                        r_wData     <= bus.ReqWData[15:0];
                        r_memAddr   <= bus.ReqAddr[ADDR_WIDTH+1:2];
                        r_respData  <= 32'h0;
                        r_respError <= w_reqError;
                        if (w_reqError) begin
                            r_state <= RESP;
                        end else if (bus.ReqWrite && (bus.ReqSize == 2'b10)) begin
                            r_memWData <= bus.ReqWData;
                            r_state    <= WR_ISSUE;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: r_state <= RD_WAIT;
                RD_WAIT: begin
                    if (r_write) begin
                        r_memWData <= w_mergeData;
                        r_state    <= WR_ISSUE;
                    end else begin
                        r_respData <= w_loadData;
                        r_state    <= RESP;
                    end
                end
                WR_ISSUE: r_state <= RESP;
                RESP:     r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign bus.ReqReady     = (r_state == IDLE) && Reset_n;
    assign bus.RespValid    = (r_state == RESP);
    assign bus.RespData     = r_respData;
    assign bus.RespError    = r_respError;
    assign bus.MemAddress   = r_memAddr;
    assign bus.MemWriteData = r_memWData;
    assign bus.MemoryRead   = (r_state == RD_ISSUE);
    assign bus.MemoryWrite  = (r_state == WR_ISSUE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Runs a little-endian and a big-endian load_store_unit side by side on the
// same request stream, each with its own word memory, and checks one of them
// per step against hand-computed values.
module tb_load_store_unit;

   localparam int AW = 6;

   logic Clock = 1'b0;
   logic Reset_n;

   always #5 Clock = ~Clock;

   load_store_unit_if #(.ADDR_WIDTH(AW)) ifLe ();
   load_store_unit_if #(.ADDR_WIDTH(AW)) ifBe ();

   load_store_unit #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dutLe (
      .Clock(Clock), .Reset_n(Reset_n), .bus(ifLe.master));
   load_store_unit #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dutBe (
      .Clock(Clock), .Reset_n(Reset_n), .bus(ifBe.master));

   logic          reqValid, reqWrite, reqSigned;
   logic [1:0]    reqSize;
   logic [AW+1:0] reqAddr;
   logic [31:0]   reqWData;

   // Both units see the identical request stream.
   assign ifLe.ReqValid  = reqValid;
   assign ifLe.ReqWrite  = reqWrite;
   assign ifLe.ReqSize   = reqSize;
   assign ifLe.ReqSigned = reqSigned;
   assign ifLe.ReqAddr   = reqAddr;
   assign ifLe.ReqWData  = reqWData;
   assign ifBe.ReqValid  = reqValid;
   assign ifBe.ReqWrite  = reqWrite;
   assign ifBe.ReqSize   = reqSize;
   assign ifBe.ReqSigned = reqSigned;
   assign ifBe.ReqAddr   = reqAddr;
   assign ifBe.ReqWData  = reqWData;

   logic [31:0]   memLe [0:63];
   logic [31:0]   memBe [0:63];
   logic          presetEn;
   logic [AW-1:0] presetAddr;
   logic [31:0]   presetData;

   // Word memories write on the falling edge; presets load both at once.
   always @(negedge Clock) begin
      if (presetEn) begin
         memLe[presetAddr] <= presetData;
         memBe[presetAddr] <= presetData;
      end else begin
         if (ifLe.MemoryWrite) memLe[ifLe.MemAddress] <= ifLe.MemWriteData;
         if (ifBe.MemoryWrite) memBe[ifBe.MemAddress] <= ifBe.MemWriteData;
      end
   end

   // Registered read data, valid the cycle after MemoryRead.
   always @(posedge Clock) begin
      if (ifLe.MemoryRead) ifLe.MemReadData <= memLe[ifLe.MemAddress];
      if (ifBe.MemoryRead) ifBe.MemReadData <= memBe[ifBe.MemAddress];
   end

   logic          selBe;
   logic          obsReady, obsRespValid, obsRespError, obsRead, obsWrite;
   logic [31:0]   obsRespData, obsWData;
   logic [AW-1:0] obsAddr;

   assign obsReady     = selBe ? ifBe.ReqReady     : ifLe.ReqReady;
   assign obsRespValid = selBe ? ifBe.RespValid    : ifLe.RespValid;
   assign obsRespError = selBe ? ifBe.RespError    : ifLe.RespError;
   assign obsRespData  = selBe ? ifBe.RespData     : ifLe.RespData;
   assign obsRead      = selBe ? ifBe.MemoryRead   : ifLe.MemoryRead;
   assign obsWrite     = selBe ? ifBe.MemoryWrite  : ifLe.MemoryWrite;
   assign obsWData     = selBe ? ifBe.MemWriteData : ifLe.MemWriteData;
   assign obsAddr      = selBe ? ifBe.MemAddress   : ifLe.MemAddress;

   int            total = 0;
   int            bad = 0;
   int            lat, nRd, nWr;
   logic [31:0]   respData;
   logic          respErr;
   logic [AW-1:0] wrAddr;

   // Single comparison point: counts, asserts, reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Loads one word into both memories while the units are idle.
   task automatic presetWord(input logic [AW-1:0] a, input logic [31:0] d);
      @(posedge Clock);
      presetEn   = 1'b1;
      presetAddr = a;
      presetData = d;
      @(negedge Clock);
      #1 presetEn = 1'b0;
   endtask

   // Issues one request, then watches 8 cycles after the accepting edge,
   // recording response latency, strobe counts and the response itself.
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [AW+1:0] a, input logic [31:0] d);
      int guard;
      @(negedge Clock);
      reqWrite  = w;
      reqSize   = sz;
      reqSigned = sg;
      reqAddr   = a;
      reqWData  = d;
      reqValid  = 1'b1;
      guard = 0;
      while (obsReady !== 1'b1 && guard < 10) begin
         @(negedge Clock);
         guard++;
      end
      checkOutput("readyBeforeAccept", {31'b0, obsReady}, 32'd1);
      @(posedge Clock);
      lat = -1; nRd = 0; nWr = 0;
      respData = 'x; respErr = 1'bx; wrAddr = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clock);
         reqValid = 1'b0;
         if (obsRead) nRd++;
         if (obsWrite) begin
            nWr++;
            wrAddr = obsAddr;
         end
         if (obsRespValid && lat < 0) begin
            lat      = c;
            respData = obsRespData;
            respErr  = obsRespError;
         end
      end
   endtask

   task automatic checkResp(input string tag, input logic [31:0] expData, input logic expErr,
                            input int expLat, input int expRd, input int expWr);
      checkOutput({tag, ".lat"},  32'(lat), 32'(expLat));
      checkOutput({tag, ".data"}, respData, expData);
      checkOutput({tag, ".err"},  {31'b0, respErr}, {31'b0, expErr});
      checkOutput({tag, ".rd"},   32'(nRd), 32'(expRd));
      checkOutput({tag, ".wr"},   32'(nWr), 32'(expWr));
   endtask

   // Bounds the whole run regardless of DUT behaviour.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int readyLow, pulses, firstPulse, secondPulse, readyAt4;

   // Directed sequence.
   initial begin
      reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
      reqAddr = '0; reqWData = '0;
      presetEn = 1'b0; presetAddr = '0; presetData = '0;
      selBe = 1'b0;
      Reset_n = 1'b0;

      repeat (2) @(negedge Clock);
      checkOutput("reset.ready",     {31'b0, obsReady},     32'd0);
      checkOutput("reset.respValid", {31'b0, obsRespValid}, 32'd0);
      checkOutput("reset.read",      {31'b0, obsRead},      32'd0);
      checkOutput("reset.write",     {31'b0, obsWrite},     32'd0);
      checkOutput("reset.respData",  obsRespData,           32'd0);
      checkOutput("reset.memAddr",   32'(obsAddr),          32'd0);
      Reset_n = 1'b1;
      @(negedge Clock);
      checkOutput("release.ready", {31'b0, obsReady}, 32'd1);

      // Word store then word load at byte 0x10 (word 4).
      applyStimulus(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
      checkResp("SW10", 32'h0, 1'b0, 2, 0, 1);
      checkOutput("SW10.addr", 32'(wrAddr), 32'd4);
      checkOutput("SW10.mem",  memLe[4], 32'hDEADBEEF);
      applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
      checkResp("LW10", 32'hDEADBEEF, 1'b0, 3, 1, 0);

      // Sub-word loads, little-endian lanes.
      presetWord(6'd4, 32'h80FF7F01);
      applyStimulus(1'b0, 2'b00, 1'b1, 8'h12, 32'h0);
      checkResp("LB12", 32'hFFFFFFFF, 1'b0, 3, 1, 0);
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h12, 32'h0);
      checkOutput("LBU12.data", respData, 32'h000000FF);
      applyStimulus(1'b0, 2'b01, 1'b1, 8'h12, 32'h0);
      checkOutput("LH12.data", respData, 32'hFFFF80FF);
      applyStimulus(1'b0, 2'b01, 1'b0, 8'h12, 32'h0);
      checkOutput("LHU12.data", respData, 32'h000080FF);
      applyStimulus(1'b0, 2'b00, 1'b1, 8'h10, 32'h0);
      checkOutput("LB10.data", respData, 32'h00000001);
      applyStimulus(1'b0, 2'b01, 1'b1, 8'h10, 32'h0);
      checkOutput("LH10.data", respData, 32'h00007F01);
      applyStimulus(1'b0, 2'b10, 1'b1, 8'h10, 32'h0);
      checkOutput("LWsigned.data", respData, 32'h80FF7F01);

      // Read-modify-write sub-word stores.
      presetWord(6'd4, 32'h11223344);
      applyStimulus(1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFFFFAA);
      checkResp("SB11", 32'h0, 1'b0, 4, 1, 1);
      checkOutput("SB11.mem", memLe[4], 32'h1122AA44);
      applyStimulus(1'b1, 2'b01, 1'b0, 8'h12, 32'h1234BEEF);
      checkResp("SH12", 32'h0, 1'b0, 4, 1, 1);
      checkOutput("SH12.mem", memLe[4], 32'hBEEFAA44);

      // Errors: no memory traffic, one-cycle turnaround.
      applyStimulus(1'b0, 2'b10, 1'b0, 8'h13, 32'h0);
      checkResp("errLW13", 32'h0, 1'b1, 1, 0, 0);
      applyStimulus(1'b0, 2'b01, 1'b1, 8'h11, 32'h0);
      checkResp("errLH11", 32'h0, 1'b1, 1, 0, 0);
      applyStimulus(1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
      checkResp("errSize", 32'h0, 1'b1, 1, 0, 0);
      applyStimulus(1'b1, 2'b10, 1'b0, 8'h12, 32'h55555555);
      checkResp("errSW12", 32'h0, 1'b1, 1, 0, 0);
      checkOutput("errSW12.mem", memLe[4], 32'hBEEFAA44);

      // Two loads back to back with ReqValid held high.
      @(negedge Clock);
      reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0; reqAddr = 8'h10; reqValid = 1'b1;
      checkOutput("b2b.readyStart", {31'b0, obsReady}, 32'd1);
      @(posedge Clock);
      readyLow = 0; pulses = 0; firstPulse = -1; secondPulse = -1; nRd = 0; readyAt4 = 0;
      respData = 'x;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clock);
         if (c <= 4 && obsReady !== 1'b1) readyLow++;
         if (c == 4) readyAt4 = int'(obsReady);
         if (c == 5) reqValid = 1'b0;
         if (obsRead) nRd++;
         if (obsRespValid) begin
            pulses++;
            if (firstPulse < 0) firstPulse = c;
            else begin
               secondPulse = c;
               respData    = obsRespData;
            end
         end
      end
      checkOutput("b2b.readyLow", 32'(readyLow), 32'd3);
      checkOutput("b2b.readyAt4", 32'(readyAt4), 32'd1);
      checkOutput("b2b.pulses",   32'(pulses),   32'd2);
      checkOutput("b2b.first",    32'(firstPulse),  32'd3);
      checkOutput("b2b.second",   32'(secondPulse), 32'd7);
      checkOutput("b2b.reads",    32'(nRd),      32'd2);
      checkOutput("b2b.data",     respData,      32'hBEEFAA44);

      // Reset pulse during RD_WAIT of a byte store aborts the write.
      presetWord(6'd4, 32'h11223344);
      @(negedge Clock);
      reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0; reqAddr = 8'h11;
      reqWData = 32'h000000AA; reqValid = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      reqValid = 1'b0;
      checkOutput("rst.rdIssue", {31'b0, obsRead}, 32'd1);
      @(negedge Clock);
      Reset_n = 1'b0;
      #1;
      checkOutput("rst.ready",     {31'b0, obsReady},     32'd0);
      checkOutput("rst.respValid", {31'b0, obsRespValid}, 32'd0);
      checkOutput("rst.respError", {31'b0, obsRespError}, 32'd0);
      checkOutput("rst.respData",  obsRespData,           32'd0);
      checkOutput("rst.memAddr",   32'(obsAddr),          32'd0);
      checkOutput("rst.memWData",  obsWData,              32'd0);
      checkOutput("rst.read",      {31'b0, obsRead},      32'd0);
      nWr = 0;
      @(negedge Clock);
      if (obsWrite) nWr++;
      Reset_n = 1'b1;
      @(negedge Clock);
      checkOutput("rst.readyAfter", {31'b0, obsReady}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         if (obsWrite) nWr++;
         @(negedge Clock);
      end
      checkOutput("rst.writes", 32'(nWr), 32'd0);
      checkOutput("rst.mem",    memLe[4], 32'h11223344);

      // Big-endian instance.
      presetWord(6'd4, 32'h11223344);
      selBe = 1'b1;
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h10, 32'h0);
      checkResp("beLBU10", 32'h00000011, 1'b0, 3, 1, 0);
      applyStimulus(1'b0, 2'b01, 1'b0, 8'h12, 32'h0);
      checkOutput("beLHU12.data", respData, 32'h00003344);
      applyStimulus(1'b1, 2'b00, 1'b0, 8'h10, 32'h000000AA);
      checkResp("beSB10", 32'h0, 1'b0, 4, 1, 1);
      checkOutput("beSB10.mem", memBe[4], 32'hAA223344);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
